// File: rtl/return_addr_stack.sv
// Return-address stack for subroutine linkage (JSB pushes PC+1, RET pops it).
// top_addr is a zero-latency read of the current top entry, so the controller
// can select it as the PC source in the same cycle it asserts pop.
// Optional macro RAS_WRAP_EN: a push into a full stack overwrites the oldest
// entry (ring storage with a base pointer). Without it, such a push is dropped.
module return_addr_stack #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic              clr_err,
   output logic [ADDR_W-1:0] top_addr,
   output logic              empty,
   output logic              full,
   output logic [LVL_W-1:0]  level,
   output logic              overflow_err,
   output logic              underflow_err
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Storage and bookkeeping state
   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [LVL_W-1:0]  level_q, level_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   // Base pointer marks the oldest entry; fixed at zero in drop-on-full builds
   logic [PTR_W-1:0]  base_c;
`ifdef RAS_WRAP_EN
   logic [PTR_W-1:0]  base_q, base_d;
   assign base_c = base_q;
`else
   assign base_c = '0;
`endif

   // Write port controls
   logic              mem_we;
   logic [PTR_W-1:0]  mem_widx;
   logic [ADDR_W-1:0] mem_wdata;

   // Derived status and indices
   logic              empty_c, full_c;
   logic [PTR_W-1:0]  top_idx_c, push_idx_c;

   assign empty_c    = (level_q == '0);
   assign full_c     = (level_q == LVL_W'(DEPTH));
   assign top_idx_c  = base_c + PTR_W'(level_q - LVL_W'(1));
   assign push_idx_c = base_c + PTR_W'(level_q);

   // Zero-latency top-of-stack read; reads as zero when the stack is empty
   assign top_addr      = empty_c ? '0 : mem_q[top_idx_c];
   assign empty         = empty_c;
   assign full          = full_c;
   assign level         = level_q;
   assign overflow_err  = ovf_q;
   assign underflow_err = unf_q;

   // Next-state: level, pointers, error flags and the single write port
   always_comb begin
      level_d   = level_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      mem_we    = 1'b0;
      mem_widx  = top_idx_c;
      mem_wdata = push_addr;
`ifdef RAS_WRAP_EN
      base_d    = base_q;
`endif

      // Clear first so an error event in the same cycle wins
      if (clr_err) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end

      case ({push, pop})
         2'b10: begin
            if (!full_c) begin
               mem_we   = 1'b1;
               mem_widx = push_idx_c;
               level_d  = level_q + LVL_W'(1);
            end else begin
               ovf_d = 1'b1;
`ifdef RAS_WRAP_EN
               // Overwrite the oldest slot; it becomes the newest top
               mem_we   = 1'b1;
               mem_widx = base_q;
               base_d   = base_q + PTR_W'(1);
`endif
            end
         end
         2'b01: begin
            if (!empty_c) begin
               level_d = level_q - LVL_W'(1);
            end else begin
               unf_d = 1'b1;
            end
         end
         2'b11: begin
            mem_we = 1'b1;
            if (!empty_c) begin
               // Replace the top entry in place
               mem_widx = top_idx_c;
            end else begin
               // Pop side underflows, push side still lands
               mem_widx = push_idx_c;
               level_d  = LVL_W'(1);
               unf_d    = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
`ifdef RAS_WRAP_EN
         base_q  <= '0;
`endif
      end else begin
         level_q <= level_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
`ifdef RAS_WRAP_EN
         base_q  <= base_d;
`endif
      end
   end

   // Entry storage, written only on clock edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[mem_widx] <= mem_wdata;
      end
   end

endmodule

// File: tb/tb_return_addr_stack.sv
// Randomized and directed checks of return_addr_stack against a queue model.
module tb_return_addr_stack;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned LVL_W  = $clog2(DEPTH + 1);

   logic              clk;
   logic              rst_n;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] push_addr;
   logic              clr_err;
   logic [ADDR_W-1:0] top_addr;
   logic              empty;
   logic              full;
   logic [LVL_W-1:0]  level;
   logic              overflow_err;
   logic              underflow_err;

   int checks = 0;
   int errors = 0;

   // Reference model: queue back = top of stack
   logic [ADDR_W-1:0] m_q[$];
   logic              m_ovf;
   logic              m_unf;

   return_addr_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .push         (push),
      .pop          (pop),
      .push_addr    (push_addr),
      .clr_err      (clr_err),
      .top_addr     (top_addr),
      .empty        (empty),
      .full         (full),
      .level        (level),
      .overflow_err (overflow_err),
      .underflow_err(underflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_top();
      if (m_q.size() == 0) return 32'd0;
      return 32'(m_q[m_q.size() - 1]);
   endfunction

   task automatic m_reset();
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // Apply one cycle of the stack rules to the model
   task automatic m_step(input logic ps, input logic pp, input logic [ADDR_W-1:0] a,
                         input logic clr);
      logic ov, un;
      ov = 1'b0;
      un = 1'b0;
      if (ps && pp) begin
         if (m_q.size() > 0) m_q[m_q.size() - 1] = a;
         else begin
            m_q.push_back(a);
            un = 1'b1;
         end
      end else if (ps) begin
         if (m_q.size() < DEPTH) m_q.push_back(a);
         else begin
            ov = 1'b1;
`ifdef RAS_WRAP_EN
            void'(m_q.pop_front());
            m_q.push_back(a);
`endif
         end
      end else if (pp) begin
         if (m_q.size() > 0) void'(m_q.pop_back());
         else un = 1'b1;
      end
      m_ovf = (m_ovf && !clr) || ov;
      m_unf = (m_unf && !clr) || un;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".level"}, 32'(level), 32'(m_q.size()));
      chk({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
      chk({tag, ".full"},  32'(full),  32'(m_q.size() == DEPTH));
      chk({tag, ".top"},   32'(top_addr), m_top());
      chk({tag, ".ovf"},   32'(overflow_err), 32'(m_ovf));
      chk({tag, ".unf"},   32'(underflow_err), 32'(m_unf));
   endtask

   // One cycle: drive, check same-cycle top, clock, check registered state
   task automatic step(input string tag, input logic ps, input logic pp,
                       input logic [ADDR_W-1:0] a, input logic clr);
      push      = ps;
      pop       = pp;
      push_addr = a;
      clr_err   = clr;
      #1;
      chk({tag, ".top_pre"}, 32'(top_addr), m_top());
      @(posedge clk);
      #1;
      m_step(ps, pp, a, clr);
      push    = 1'b0;
      pop     = 1'b0;
      clr_err = 1'b0;
      check_all(tag);
   endtask

   initial begin
      push = 0; pop = 0; push_addr = '0; clr_err = 0;
      rst_n = 0;
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      check_all("reset");

      // Idle after reset
      for (int i = 0; i < 3; i++) step("idle", 0, 0, 12'h000, 0);

      // Basic LIFO
      step("push1", 1, 0, 12'h010, 0);
      step("push2", 1, 0, 12'h020, 0);
      step("push3", 1, 0, 12'h030, 0);
      chk("lifo.level3", 32'(level), 32'd3);
      chk("lifo.top30", 32'(top_addr), 32'h030);
      push = 0; pop = 1; #1;
      chk("lifo.pop_top30", 32'(top_addr), 32'h030);
      step("pop1", 0, 1, 12'h000, 0);
      pop = 1; #1;
      chk("lifo.pop_top20", 32'(top_addr), 32'h020);
      step("pop2", 0, 1, 12'h000, 0);
      pop = 1; #1;
      chk("lifo.pop_top10", 32'(top_addr), 32'h010);
      step("pop3", 0, 1, 12'h000, 0);
      chk("lifo.empty", 32'(empty), 32'd1);

      // Underflow and clear
      step("unf", 0, 1, 12'h000, 0);
      chk("unf.flag", 32'(underflow_err), 32'd1);
      chk("unf.level", 32'(level), 32'd0);
      step("unf_clr", 0, 0, 12'h000, 1);
      chk("unf.cleared", 32'(underflow_err), 32'd0);

      // Fill, then push into a full stack
      for (int i = 0; i < 8; i++) step("fill", 1, 0, 12'(12'h100 + i), 0);
      chk("fill.full", 32'(full), 32'd1);
      step("ovf", 1, 0, 12'h1FF, 0);
      chk("ovf.flag", 32'(overflow_err), 32'd1);
`ifdef RAS_WRAP_EN
      chk("ovf.top", 32'(top_addr), 32'h1FF);
      for (int i = 0; i < 8; i++) begin
         logic [31:0] exp_top;
         exp_top = (i == 0) ? 32'h1FF : 32'(12'h107 - (i - 1));
         pop = 1; #1;
         chk("wrap.pop_top", 32'(top_addr), exp_top);
         step("wrap_pop", 0, 1, 12'h000, 0);
      end
`else
      chk("ovf.top", 32'(top_addr), 32'h107);
      for (int i = 0; i < 8; i++) begin
         pop = 1; #1;
         chk("drop.pop_top", 32'(top_addr), 32'(12'h107 - i));
         step("drop_pop", 0, 1, 12'h000, 0);
      end
`endif
      chk("drain.empty", 32'(empty), 32'd1);
      // Error set wins over a simultaneous clear
      step("clr_vs_unf", 0, 1, 12'h000, 1);
      chk("clr_vs_unf.unf", 32'(underflow_err), 32'd1);
      chk("clr_vs_unf.ovf", 32'(overflow_err), 32'd0);
      step("clr", 0, 0, 12'h000, 1);

      // Simultaneous push and pop replaces top
      step("pp_a", 1, 0, 12'h040, 0);
      step("pp_b", 1, 0, 12'h050, 0);
      step("pp_rep", 1, 1, 12'h060, 0);
      chk("pp.level", 32'(level), 32'd2);
      chk("pp.top", 32'(top_addr), 32'h060);
      chk("pp.unf", 32'(underflow_err), 32'd0);
      step("pp_pop", 0, 1, 12'h000, 0);
      chk("pp.pop_top", 32'(top_addr), 32'h040);
      step("pp_pop2", 0, 1, 12'h000, 0);
      // Push and pop on empty: push lands, underflow flagged
      step("pp_empty", 1, 1, 12'h0AB, 0);
      chk("pp_empty.level", 32'(level), 32'd1);
      chk("pp_empty.unf", 32'(underflow_err), 32'd1);
      step("pp_empty_pop", 0, 1, 12'h000, 1);

      // Asynchronous reset between edges at level 5
      for (int i = 0; i < 5; i++) step("pre_rst", 1, 0, 12'($urandom), 0);
      chk("pre_rst.level", 32'(level), 32'd5);
      #2 rst_n = 0;
      #1;
      m_reset();
      check_all("async_rst");
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      check_all("post_rst");

      // Randomized traffic with phases biased toward fill and drain
      for (int i = 0; i < 600; i++) begin
         int r;
         int bias;
         logic ps, pp, cl;
         bias = ((i / 40) % 2 == 0) ? 70 : 30;
         r  = int'($urandom_range(0, 99));
         ps = (r < bias);
         pp = (int'($urandom_range(0, 99)) < (100 - bias));
         cl = ($urandom_range(0, 15) == 0);
         step("rand", ps, pp, 12'($urandom), cl);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
